// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter of NUM_REQUESTERS IO request channels onto one device port.
// Optional per-channel saturating grant counters are built when IO_ARB_STATS_EN is defined.
module io_bus_arbiter #(
    parameter int  NUM_REQUESTERS   = 4,
    parameter int  THREAD_IDX_WIDTH = 2,
    parameter int  IO_LATENCY       = 1,
    localparam int REQ_IDX_WIDTH    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQUESTERS-1:0]                    req_valid,
    input  logic [NUM_REQUESTERS-1:0]                    req_store,
    input  logic [NUM_REQUESTERS*32-1:0]                 req_address,
    input  logic [NUM_REQUESTERS*32-1:0]                 req_data,
    input  logic [NUM_REQUESTERS*THREAD_IDX_WIDTH-1:0]   req_thread,
    output logic [NUM_REQUESTERS-1:0]                    req_ready,
    output logic                                         io_write_en,
    output logic                                         io_read_en,
    output logic [31:0]                                  io_address,
    output logic [31:0]                                  io_write_data,
    input  logic [31:0]                                  io_read_data,
    output logic                                         rsp_valid,
    output logic                                         rsp_store,
    output logic [REQ_IDX_WIDTH-1:0]                     rsp_requester,
    output logic [THREAD_IDX_WIDTH-1:0]                  rsp_thread,
    output logic [31:0]                                  rsp_read_data
`ifdef IO_ARB_STATS_EN
    ,
    input  logic                                         stats_clear,
    output logic [NUM_REQUESTERS*16-1:0]                 grant_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t                                         state_q, state_d;
    logic [REQ_IDX_WIDTH-1:0]                       ptr_q, ptr_d, win;
    logic                                           any_valid, grant;
    logic [3:0]                                     cnt_q, cnt_d;

    logic                                           store_q;
    logic [31:0]                                    addr_q, wdata_q;
    logic [THREAD_IDX_WIDTH-1:0]                    thread_q;
    logic [REQ_IDX_WIDTH-1:0]                       idx_q;

    logic                                           rsp_store_q;
    logic [REQ_IDX_WIDTH-1:0]                       rsp_req_q;
    logic [THREAD_IDX_WIDTH-1:0]                    rsp_thread_q;
    logic [31:0]                                    rsp_data_q;

    logic [NUM_REQUESTERS-1:0][31:0]                addr_arr, data_arr;
    logic [NUM_REQUESTERS-1:0][THREAD_IDX_WIDTH-1:0] thread_arr;

    assign addr_arr   = req_address;
    assign data_arr   = req_data;
    assign thread_arr = req_thread;

    // First valid channel at or after the pointer; cand carries one extra bit for the wrap.
    always_comb begin
        logic [REQ_IDX_WIDTH:0] cand;
        cand      = '0;
        win       = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            cand = {1'b0, ptr_q} + (REQ_IDX_WIDTH+1)'(k);
            if (cand >= (REQ_IDX_WIDTH+1)'(NUM_REQUESTERS))
                cand = cand - (REQ_IDX_WIDTH+1)'(NUM_REQUESTERS);
            if (!any_valid && req_valid[cand[REQ_IDX_WIDTH-1:0]]) begin
                any_valid = 1'b1;
                win       = cand[REQ_IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            // RESPOND doubles as an arbitration slot so back-to-back requests lose no cycle.
            IDLE, RESPOND: begin
                state_d = IDLE;
                if (any_valid) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                    ptr_d   = (win == REQ_IDX_WIDTH'(NUM_REQUESTERS-1)) ? '0
                                                                        : win + REQ_IDX_WIDTH'(1);
                end
            end
            ISSUE: begin
                cnt_d   = 4'(IO_LATENCY-1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESPOND;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            thread_q     <= '0;
            idx_q        <= '0;
            rsp_store_q  <= 1'b0;
            rsp_req_q    <= '0;
            rsp_thread_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                store_q  <= req_store[win];
                addr_q   <= addr_arr[win];
                wdata_q  <= data_arr[win];
                thread_q <= thread_arr[win];
                idx_q    <= win;
            end
            // Response fields change only on the edge that enters RESPOND, so they hold otherwise.
            if (state_q == WAIT && cnt_q == 4'd0) begin
                rsp_store_q  <= store_q;
                rsp_req_q    <= idx_q;
                rsp_thread_q <= thread_q;
                rsp_data_q   <= store_q ? '0 : io_read_data;
            end
        end
    end

    assign io_read_en    = (state_q == ISSUE) && !store_q;
    assign io_write_en   = (state_q == ISSUE) &&  store_q;
    assign io_address    = addr_q;
    assign io_write_data = wdata_q;

    assign rsp_valid     = (state_q == RESPOND);
    assign rsp_store     = rsp_store_q;
    assign rsp_requester = rsp_req_q;
    assign rsp_thread    = rsp_thread_q;
    assign rsp_read_data = rsp_data_q;

`ifdef IO_ARB_STATS_EN
    logic [NUM_REQUESTERS-1:0][15:0] gcnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gcnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (stats_clear)
                    gcnt_q[i] <= '0;
                else if (grant && win == REQ_IDX_WIDTH'(i) && gcnt_q[i] != 16'hFFFF)
                    gcnt_q[i] <= gcnt_q[i] + 16'd1;
            end
        end
    end

    assign grant_count = gcnt_q;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter (4 channels, IO_LATENCY=3) with a fixed-latency device model.
module tb_io_bus_arbiter;

    localparam int N   = 4;
    localparam int TW  = 2;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_store, req_ready;
    logic [N*32-1:0] req_address, req_data;
    logic [N*TW-1:0] req_thread;
    logic            io_write_en, io_read_en;
    logic [31:0]     io_address, io_write_data, io_read_data;
    logic            rsp_valid, rsp_store;
    logic [1:0]      rsp_requester;
    logic [TW-1:0]   rsp_thread;
    logic [31:0]     rsp_read_data;
`ifdef IO_ARB_STATS_EN
    logic            stats_clear = 1'b0;
    logic [N*16-1:0] grant_count;
`endif

    io_bus_arbiter #(.NUM_REQUESTERS(N), .THREAD_IDX_WIDTH(TW), .IO_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_address(req_address),
        .req_data(req_data), .req_thread(req_thread), .req_ready(req_ready),
        .io_write_en(io_write_en), .io_read_en(io_read_en), .io_address(io_address),
        .io_write_data(io_write_data), .io_read_data(io_read_data),
        .rsp_valid(rsp_valid), .rsp_store(rsp_store), .rsp_requester(rsp_requester),
        .rsp_thread(rsp_thread), .rsp_read_data(rsp_read_data)
`ifdef IO_ARB_STATS_EN
        , .stats_clear(stats_clear), .grant_count(grant_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed per-channel request fields and hand-computed read results.
    logic [N-1:0][31:0]   ch_addr, ch_data, ch_exp;
    logic [N-1:0][TW-1:0] ch_thr;
    logic [N-1:0]         ch_st;
    assign req_address = ch_addr;
    assign req_data    = ch_data;
    assign req_thread  = ch_thr;
    assign req_store   = ch_st;

    // Device: data for the word addressed in the strobe cycle appears exactly LAT cycles later.
    logic [31:0] dev_mem [64];
    logic [2:0]  rd_pipe = '0;
    logic [31:0] rd_word [3];
    always @(posedge clk) begin
        rd_pipe    <= {rd_pipe[1:0], io_read_en};
        rd_word[0] <= dev_mem[io_address[7:2]];
        rd_word[1] <= rd_word[0];
        rd_word[2] <= rd_word[1];
    end
    assign io_read_data = rd_pipe[2] ? rd_word[2] : 32'hBADBAD00;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  thr;
        logic        st;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    // Monitor: every response pulse must match the oldest expected entry, on the predicted cycle.
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_rsp: got requester %0d, expected no response", rsp_requester);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_requester", 32'(rsp_requester), 32'(mon_e.req));
                chk("rsp_thread",    32'(rsp_thread),    32'(mon_e.thr));
                chk("rsp_store",     32'(rsp_store),     32'(mon_e.st));
                chk("rsp_read_data", rsp_read_data,      mon_e.data);
                chk("rsp_cycle",     32'(cyc),           32'(mon_e.cyc));
            end
        end
    end

    // Raise mask, then expect grants in 'order' (one channel per nibble).
    task automatic run_grants(input logic [3:0] mask, input int n, input logic [31:0] order,
                              input bit hold);
        int   c;
        int   last_g;
        bit   got;
        exp_t e;
        @(posedge clk); #1;
        req_valid = req_valid | mask;
        last_g = -1;
        for (int k = 0; k < n; k++) begin
            c   = int'(order[4*k +: 4]);
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (req_ready != '0) got = 1'b1;
            end
            if (!got) begin
                n_chk++;
                $display("FAIL grant_timeout: got no req_ready, expected grant to channel %0d", c);
                req_valid = req_valid & ~mask;
                return;
            end
            chk("grant_onehot", 32'(req_ready), 32'(4'b0001 << c));
            if (last_g >= 0) chk("grant_spacing", 32'(cyc - last_g), 32'(LAT + 2));
            last_g = cyc;
            e.req  = 2'(c);
            e.thr  = ch_thr[c];
            e.st   = ch_st[c];
            e.data = ch_exp[c];
            e.cyc  = cyc + LAT + 2;
            sb.push_back(e);
            @(posedge clk); #1;
            if (!hold) req_valid[c] = 1'b0;
            @(negedge clk);
            chk("io_read_en",  32'(io_read_en),  32'(!ch_st[c]));
            chk("io_write_en", 32'(io_write_en), 32'(ch_st[c]));
            chk("io_address",  io_address,       ch_addr[c]);
            if (ch_st[c]) chk("io_write_data", io_write_data, ch_data[c]);
            @(negedge clk);
            chk("strobe_one_cycle", 32'({io_read_en, io_write_en}), 32'd0);
        end
        if (hold) req_valid = req_valid & ~mask;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_io_en"},     32'({io_read_en, io_write_en}), 32'd0);
        chk({tag, "_io_addr"},   io_address, 32'd0);
        chk({tag, "_io_wdata"},  io_write_data, 32'd0);
        chk({tag, "_rsp"},       32'({rsp_valid, rsp_store, rsp_requester, rsp_thread}), 32'd0);
        chk({tag, "_rsp_data"},  rsp_read_data, 32'd0);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 64; i++) dev_mem[i] = 32'h0;
        dev_mem[1] = 32'h12345678;   // 0xFFFF0004
        dev_mem[2] = 32'h00001111;   // 0xFFFF0008
        dev_mem[8] = 32'hA5A50003;   // 0xFFFF0020
        ch_addr = {32'hFFFF0020, 32'hFFFF0004, 32'hFFFF0008, 32'hFFFF0010};
        ch_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        ch_exp  = {32'hA5A50003, 32'h12345678, 32'h00001111, 32'h00000000};
        ch_thr  = {2'd0, 2'd1, 2'd2, 2'd3};
        ch_st   = 4'b0001;
        req_valid = '0;
        reset     = 1'b0;
        #2;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Single read on channel 2, thread 1.
        run_grants(4'b0100, 1, 32'h2, 1'b0);
        drain();
        // Pointer at 3 with channels 1 and 3: wrap order 3 then 1.
        run_grants(4'b1010, 2, 32'h13, 1'b0);
        drain();
        // Pointer now 2: channel 2 beats channel 1.
        run_grants(4'b0110, 2, 32'h12, 1'b0);
        drain();
        // Write on channel 0.
        run_grants(4'b0001, 1, 32'h0, 1'b0);
        drain();

        // Abort channel 1 read during WAIT.
        run_grants(4'b0010, 1, 32'h1, 1'b0);
        #1 reset = 1'b0;
        void'(sb.pop_back());
        #1;
        chk_all_zero("abort");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);

        // All channels held: strict rotation from pointer 0.
        run_grants(4'b1111, 6, 32'h103210, 1'b1);
        drain();

`ifdef IO_ARB_STATS_EN
        chk("grant_count1", 32'(grant_count[31:16]), 32'd2);
        @(posedge clk); #1 stats_clear = 1'b1;
        @(posedge clk); #1 stats_clear = 1'b0;
        @(negedge clk);
        chk("grant_count1_clear", 32'(grant_count[31:16]), 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
